// File: rtl/mux_display_controller.sv
// Time-multiplexed common-anode seven-segment driver with inter-digit blanking and heartbeat LED.
// Optional leading-zero suppression is enabled by defining LEADING_ZERO_BLANK_EN.
module mux_display_controller #(
    parameter int NUM_DIGITS    = 2,
    parameter int REFRESH_DIV   = 100000,
    parameter int BLANK_CYCLES  = 1000,
    parameter int HEARTBEAT_DIV = 24000000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] s,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    led
);

    localparam int CW = (REFRESH_DIV   > 1) ? $clog2(REFRESH_DIV)   : 1;
    localparam int IW = (NUM_DIGITS    > 1) ? $clog2(NUM_DIGITS)    : 1;
    localparam int HW = (HEARTBEAT_DIV > 1) ? $clog2(HEARTBEAT_DIV) : 1;

    localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);
    localparam logic [HW-1:0] HB_LAST   = HW'(HEARTBEAT_DIV - 1);

    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [3:0]            val_q, val_d;
    logic [HW-1:0]         hb_q, hb_d;
    logic [6:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  led_q, led_d;
    logic                  slot_end, hb_wrap, lit;
    logic [3:0]            nib;
`ifdef LEADING_ZERO_BLANK_EN
    logic                  sup_q, sup_d, zero_above;
`endif

    function automatic logic [6:0] hex_font(input logic [3:0] v);
        case (v)
            4'h0: hex_font = 7'b1000000;
            4'h1: hex_font = 7'b1111001;
            4'h2: hex_font = 7'b0100100;
            4'h3: hex_font = 7'b0110000;
            4'h4: hex_font = 7'b0011001;
            4'h5: hex_font = 7'b0010010;
            4'h6: hex_font = 7'b0000010;
            4'h7: hex_font = 7'b1111000;
            4'h8: hex_font = 7'b0000000;
            4'h9: hex_font = 7'b0010000;
            4'hA: hex_font = 7'b0001000;
            4'hB: hex_font = 7'b0000011;
            4'hC: hex_font = 7'b1000110;
            4'hD: hex_font = 7'b0100001;
            4'hE: hex_font = 7'b0000110;
            default: hex_font = 7'b0001110;
        endcase
    endfunction

    always_comb begin
        slot_end = (cnt_q == CNT_LAST);
        cnt_d    = slot_end ? '0 : cnt_q + CW'(1);
        idx_d    = idx_q;
        if (slot_end)
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);

        // Nibble for the digit about to be shown, latched only at slot start.
        nib = s[3:0];
        for (int k = 0; k < NUM_DIGITS; k++)
            if (idx_d == IW'(k)) nib = s[4*k +: 4];
        val_d = slot_end ? nib : val_q;

        hb_wrap = (hb_q == HB_LAST);
        hb_d    = hb_wrap ? '0 : hb_q + HW'(1);
        led_d   = led_q ^ hb_wrap;

        lit = (cnt_q >= BLANK_END);
`ifdef LEADING_ZERO_BLANK_EN
        zero_above = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++)
            if (IW'(k) >= idx_d && s[4*k +: 4] != 4'h0) zero_above = 1'b0;
        sup_d = slot_end ? (zero_above && idx_d != '0) : sup_q;
        lit   = lit && !sup_q;
`endif

        an_d = '1;
        for (int k = 0; k < NUM_DIGITS; k++)
            an_d[k] = !(lit && idx_q == IW'(k));
        seg_d = lit ? hex_font(val_q) : 7'h7F;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
            idx_q <= '0;
            val_q <= s[3:0];
            hb_q  <= '0;
            an_q  <= '1;
            seg_q <= 7'h7F;
            led_q <= 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
            sup_q <= 1'b0;
`endif
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            val_q <= val_d;
            hb_q  <= hb_d;
            an_q  <= an_d;
            seg_q <= seg_d;
            led_q <= led_d;
`ifdef LEADING_ZERO_BLANK_EN
            sup_q <= sup_d;
`endif
        end
    end

    assign seg = seg_q;
    assign an  = an_q;
    assign led = led_q;

endmodule

// File: tb/tb_mux_display_controller.sv
// Randomized bench for mux_display_controller against a cycle-index arithmetic model.
module tb_mux_display_controller;
    localparam int ND = 2, RD = 8, BC = 2, HD = 5;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [4*ND-1:0] s = '0;
    logic [6:0]      seg;
    logic [ND-1:0]   an;
    logic            led;

    int checks = 0, errors = 0, k = 0;
    logic [4*ND-1:0] sh [0:1023];
    logic [6:0] font [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                              7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                              7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    mux_display_controller #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYCLES(BC),
                             .HEARTBEAT_DIV(HD)) dut (
        .clk(clk), .reset(reset), .s(s), .seg(seg), .an(an), .led(led));

    always #5 clk = ~clk;

    // Expected {an, seg, led} in interval kk after release; sh[m] is s seen at edge m.
    function automatic logic [ND+7:0] exp_out(input int kk);
        logic [ND-1:0]   a;
        logic [6:0]      sg;
        logic [4*ND-1:0] lat;
        int n, slot, idx;
        bit sup;
        a = '1; sg = 7'h7F; sup = 0;
        if (kk > 0) begin
            n    = kk - 1;
            slot = n / RD;
            idx  = slot % ND;
            lat  = sh[slot*RD];
`ifdef LEADING_ZERO_BLANK_EN
            sup = (idx > 0) && ((lat >> (4*idx)) == '0);
`endif
            if ((n % RD) >= BC && !sup) begin
                a[idx] = 1'b0;
                sg = font[lat[4*idx +: 4]];
            end
        end
        return {a, sg, 1'(((kk / HD) % 2) == 1)};
    endfunction

    task automatic start(input logic [4*ND-1:0] v, input int n);
        reset = 1'b0;
        s = v;
        repeat (n) begin
            @(posedge clk); #1;
            checks++;
            if ({an, seg, led} !== {{ND{1'b1}}, 7'h7F, 1'b0}) begin
                errors++;
                $display("FAIL reset_hold got an=%b seg=%b led=%b exp an=all1 seg=1111111 led=0", an, seg, led);
            end
        end
        reset = 1'b1;
        k = 0;
        sh[0] = v;
    endtask

    task automatic drive(input logic [4*ND-1:0] v);
        s = v;
        sh[k+1] = v;
        @(negedge clk);
    endtask

    task automatic adv();
        @(posedge clk); #1;
        k++;
    endtask

    task automatic test_reset();
        logic [ND+7:0] e;
        start(8'h3A, 3);
        for (int i = 0; i < 24; i++) begin
            drive(8'h3A);
            e = exp_out(k); checks++;
            if ({an, seg, led} !== e) begin errors++; $display("FAIL reset_seq k=%0d got %b exp %b", k, {an, seg, led}, e); end
            if (i == 2) begin
                checks++;
                if (an !== 2'b11 || seg !== 7'h7F) begin errors++; $display("FAIL reset_blank2 got an=%b seg=%b exp an=11 seg=1111111", an, seg); end
            end
            if (i == 3) begin
                checks++;
                if (an !== 2'b10 || seg !== 7'b0001000) begin errors++; $display("FAIL reset_first_lit got an=%b seg=%b exp an=10 seg=0001000", an, seg); end
            end
            adv();
        end
    endtask

    task automatic test_decode();
        logic [ND+7:0] e;
        start(8'hF1, 1);
        for (int i = 0; i < 48; i++) begin
            drive(8'hF1);
            e = exp_out(k); checks++;
            if ({an, seg, led} !== e) begin errors++; $display("FAIL decode k=%0d got %b exp %b", k, {an, seg, led}, e); end
            checks++;
            if (an === 2'b00) begin errors++; $display("FAIL decode_two_anodes k=%0d got an=%b exp at most one low", k, an); end
            if (i == 3 || i == 19) begin
                checks++;
                if (an !== 2'b10 || seg !== 7'b1111001) begin errors++; $display("FAIL decode_d0 k=%0d got an=%b seg=%b exp an=10 seg=1111001", k, an, seg); end
            end
            if (i == 11 || i == 27) begin
                checks++;
                if (an !== 2'b01 || seg !== 7'b0001110) begin errors++; $display("FAIL decode_d1 k=%0d got an=%b seg=%b exp an=01 seg=0001110", k, an, seg); end
            end
            adv();
        end
    endtask

    task automatic test_mid_slot_latch();
        logic [ND+7:0] e;
        start(8'h00, 1);
        for (int i = 0; i < 20; i++) begin
            drive((i >= 4) ? 8'h88 : 8'h00);
            e = exp_out(k); checks++;
            if ({an, seg, led} !== e) begin errors++; $display("FAIL latch k=%0d got %b exp %b", k, {an, seg, led}, e); end
            if (i >= 3 && i <= 8) begin
                checks++;
                if (seg !== 7'b1000000) begin errors++; $display("FAIL latch_hold k=%0d got seg=%b exp 1000000", k, seg); end
            end
            if (i >= 11 && i <= 16) begin
                checks++;
                if (an !== 2'b01 || seg !== 7'b0000000) begin errors++; $display("FAIL latch_next k=%0d got an=%b seg=%b exp an=01 seg=0000000", k, an, seg); end
            end
            adv();
        end
    endtask

    task automatic test_heartbeat();
        logic [ND+7:0] e;
        logic prev;
        start(8'($urandom), 1);
        prev = 1'b0;
        for (int i = 0; i < 21; i++) begin
            drive(8'($urandom));
            e = exp_out(k); checks++;
            if ({an, seg, led} !== e) begin errors++; $display("FAIL hb_model k=%0d got %b exp %b", k, {an, seg, led}, e); end
            checks++;
            if (led !== ((i > 0 && i % 5 == 0) ? ~prev : prev)) begin
                errors++; $display("FAIL hb_toggle cycle=%0d got led=%b prev=%b", i, led, prev);
            end
            prev = led;
            adv();
        end
    endtask

    task automatic test_reset_mid();
        logic [ND+7:0] e;
        start(8'h5C, 1);
        for (int i = 0; i < 14; i++) begin
            drive(8'h5C);
            e = exp_out(k); checks++;
            if ({an, seg, led} !== e) begin errors++; $display("FAIL rmid_pre k=%0d got %b exp %b", k, {an, seg, led}, e); end
            if (i < 13) adv();
        end
        start(8'h5C, 1);
        for (int i = 0; i < 20; i++) begin
            drive(8'h5C);
            e = exp_out(k); checks++;
            if ({an, seg, led} !== e) begin errors++; $display("FAIL rmid_post k=%0d got %b exp %b", k, {an, seg, led}, e); end
            if (i == 1 || i == 2) begin
                checks++;
                if (an !== 2'b11) begin errors++; $display("FAIL rmid_blank k=%0d got an=%b exp 11", k, an); end
            end
            if (i == 3) begin
                checks++;
                if (an !== 2'b10 || seg !== 7'b0011001 ^ 7'b0) begin
                    if (an !== 2'b10 || seg !== font[4'hC]) begin errors++; $display("FAIL rmid_first_lit got an=%b seg=%b exp an=10 seg=%b", an, seg, font[4'hC]); end
                end
            end
            adv();
        end
    endtask

    task automatic test_random();
        logic [ND+7:0] e;
        logic [4*ND-1:0] v;
        v = 8'($urandom);
        start(v, 2);
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                v[3:0] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
                v[7:4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            end
            drive(v);
            e = exp_out(k); checks++;
            if ({an, seg, led} !== e) begin errors++; $display("FAIL random k=%0d s=%h got %b exp %b", k, v, {an, seg, led}, e); end
            checks++;
            if (an === 2'b00) begin errors++; $display("FAIL random_two_anodes k=%0d got an=%b", k, an); end
            adv();
        end
    endtask

`ifdef LEADING_ZERO_BLANK_EN
    task automatic test_lzb();
        logic [ND+7:0] e;
        for (int pass = 0; pass < 2; pass++) begin
            start((pass == 0) ? 8'h05 : 8'h00, 1);
            for (int i = 0; i < 32; i++) begin
                drive((pass == 0) ? 8'h05 : 8'h00);
                e = exp_out(k); checks++;
                if ({an, seg, led} !== e) begin errors++; $display("FAIL lzb k=%0d got %b exp %b", k, {an, seg, led}, e); end
                if (i >= 9 && i <= 16) begin
                    checks++;
                    if (an !== 2'b11 || seg !== 7'h7F) begin errors++; $display("FAIL lzb_d1 k=%0d got an=%b seg=%b exp an=11 seg=1111111", k, an, seg); end
                end
                if (i == 3) begin
                    checks++;
                    if (an !== 2'b10 || seg !== ((pass == 0) ? 7'b0010010 : 7'b1000000)) begin
                        errors++; $display("FAIL lzb_d0 pass=%0d got an=%b seg=%b", pass, an, seg);
                    end
                end
                adv();
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_decode();
        test_mid_slot_latch();
        test_heartbeat();
        test_reset_mid();
        test_random();
`ifdef LEADING_ZERO_BLANK_EN
        test_lzb();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
